// File: rtl/axil_coef_pkg.sv
// Shared response codes, FSM state types and the byte-strobe merge helper
// for the FIR coefficient AXI4-Lite register file.
package axil_coef_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Sized for the widest supported bus; 32-bit callers zero-extend and truncate.
    function automatic logic [63:0] strb_merge(
        input logic [63:0] old_val,
        input logic [63:0] new_val,
        input logic [7:0]  strb
    );
        logic [63:0] merged;
        merged = old_val;
        for (int unsigned b = 0; b < 8; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_wr_ctrl.sv
// AXI4-Lite write channel controller: AW/W capture, write FSM and B channel.
// Presents a single-cycle commit (index, data, strobes) to the register array.
module axil_wr_ctrl
    import axil_coef_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 6,
    parameter int unsigned NUM_RW   = 8,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [AW-1:0]          i_awaddr,
    input  logic                   i_awvalid,
    output logic                   o_awready,
    input  logic [DW-1:0]          i_wdata,
    input  logic [DW/8-1:0]        i_wstrb,
    input  logic                   i_wvalid,
    output logic                   o_wready,
    output logic [1:0]             o_bresp,
    output logic                   o_bvalid,
    input  logic                   i_bready,
    output logic                   o_wr_en,
    output logic [AW-ADDR_LSB-1:0] o_wr_idx,
    output logic [DW-1:0]          o_wr_data,
    output logic [DW/8-1:0]        o_wr_strb
);

    wr_state_t r_state;
    wr_state_t w_next;

    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;
    logic [1:0]      r_bresp;
    logic [AW-1:0]   r_awaddr;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_wstrb;

    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_b_hs;
    logic            w_commit;
    logic            w_mapped;
    logic [AW-1:0]   w_addr;
    logic            w_unused;

    assign w_aw_hs = i_awvalid & r_awready;
    assign w_w_hs  = i_wvalid & r_wready;
    assign w_b_hs  = r_bvalid & i_bready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_next = W_HAVE_A;
                end else if (w_w_hs) begin
                    w_next = W_HAVE_D;
                end
            end
            W_HAVE_A: if (w_w_hs)  w_next = W_RESP;
            W_HAVE_D: if (w_aw_hs) w_next = W_RESP;
            W_RESP:   if (w_b_hs)  w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    // The last handshake may be on either channel, so each half of the
    // transaction comes from its latch or straight off the bus.
    assign w_commit  = (w_next == W_RESP) && (r_state != W_RESP);
    assign w_addr    = (r_state == W_HAVE_A) ? r_awaddr : i_awaddr;
    assign o_wr_data = (r_state == W_HAVE_D) ? r_wdata  : i_wdata;
    assign o_wr_strb = (r_state == W_HAVE_D) ? r_wstrb  : i_wstrb;
    assign o_wr_idx  = w_addr[AW-1:ADDR_LSB];
    assign w_mapped  = 32'(o_wr_idx) < NUM_RW;
    assign o_wr_en   = w_commit & w_mapped;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_awready <= (w_next == W_IDLE) || (w_next == W_HAVE_D);
            r_wready  <= (w_next == W_IDLE) || (w_next == W_HAVE_A);
            if (w_aw_hs) begin
                r_awaddr <= i_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;

    assign w_unused = &{1'b0, w_addr[ADDR_LSB-1:0]};

endmodule

// File: rtl/axil_coef_regfile.sv
// Parametrised AXI4-Lite register file for the FIR filter: RW coefficient/control
// registers with byte strobes, RO status words, SLVERR on unmapped accesses.
module axil_coef_regfile
    import axil_coef_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_RW             = 8,
    parameter int unsigned NUM_RO             = 2
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_RW-1:0]                    wr_pulse_o,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] status_i
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned ADDR_LSB = (DW == 64) ? 3 : 2;
    localparam int unsigned IDX_W    = AW - ADDR_LSB;

    logic [DW-1:0]     r_regs [NUM_RW];
    logic [NUM_RW-1:0] r_wr_pulse;

    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [DW-1:0]     w_wr_data;
    logic [DW/8-1:0]   w_wr_strb;

    rd_state_t         r_rstate;
    rd_state_t         w_rnext;
    logic              r_arready;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic [DW-1:0]     r_rdata;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic [IDX_W-1:0]  w_ar_idx;
    logic [DW-1:0]     w_rd_data;
    logic [1:0]        w_rd_resp;
    logic              w_unused;

    axil_wr_ctrl #(
        .DW       (DW),
        .AW       (AW),
        .NUM_RW   (NUM_RW),
        .ADDR_LSB (ADDR_LSB)
    ) u_wr_ctrl (
        .i_clk     (ACLK),
        .i_rst     (ARESET),
        .i_awaddr  (S_AXI_AWADDR),
        .i_awvalid (S_AXI_AWVALID),
        .o_awready (S_AXI_AWREADY),
        .i_wdata   (S_AXI_WDATA),
        .i_wstrb   (S_AXI_WSTRB),
        .i_wvalid  (S_AXI_WVALID),
        .o_wready  (S_AXI_WREADY),
        .o_bresp   (S_AXI_BRESP),
        .o_bvalid  (S_AXI_BVALID),
        .i_bready  (S_AXI_BREADY),
        .o_wr_en   (w_wr_en),
        .o_wr_idx  (w_wr_idx),
        .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int unsigned k = 0; k < NUM_RW; k++) begin
                r_regs[k] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            for (int unsigned k = 0; k < NUM_RW; k++) begin
                if (w_wr_en && (32'(w_wr_idx) == k)) begin
                    r_regs[k]     <= DW'(strb_merge(64'(r_regs[k]), 64'(w_wr_data), 8'(w_wr_strb)));
                    r_wr_pulse[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int unsigned k = 0; k < NUM_RW; k++) begin
            regs_o[k*DW +: DW] = r_regs[k];
        end
    end

    assign wr_pulse_o = r_wr_pulse;

    assign w_ar_hs  = S_AXI_ARVALID & r_arready;
    assign w_r_hs   = r_rvalid & S_AXI_RREADY;
    assign w_ar_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
            R_DATA:  if (w_r_hs)  w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read mux sees the register array before any same-edge write commit.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        for (int unsigned k = 0; k < NUM_RW; k++) begin
            if (32'(w_ar_idx) == k) begin
                w_rd_data = r_regs[k];
                w_rd_resp = RESP_OKAY;
            end
        end
        for (int unsigned j = 0; j < NUM_RO; j++) begin
            if (32'(w_ar_idx) == NUM_RW + j) begin
                w_rd_data = status_i[j*DW +: DW];
                w_rd_resp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_arready <= (w_rnext == R_IDLE);
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule
